// File: rtl/mcu_spi_target.sv
// SPI mode-0 target for the MCU link: oversamples SCLK/CSn/MOSI in the clk domain,
// delivers received bytes as strobes and shifts the control block's response out on MISO.
module mcu_spi_target #(
  parameter logic MISO_IDLE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       data_in_strobe,
  output logic       data_in_start,
  output logic [7:0] data_in,
  input  logic [7:0] data_out
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  // [0],[1] are the synchroniser stages, [2] holds the previous synced value
  logic [2:0] csn_sync_r;
  logic [2:0] sclk_sync_r;
  logic [1:0] mosi_sync_r;

  logic       mosi_s;
  logic       csn_s;
  logic       rise_s;
  logic       fall_s;
  logic       cs_fall_s;
  logic       cs_rise_s;

  state_t     state_r;
  logic [7:0] rx_sr_r;
  logic [7:0] tx_sr_r;
  logic [7:0] data_in_r;
  logic [2:0] bit_cnt_r;
  logic       first_r;
  logic       strobe_r;
  logic       start_r;
  logic       miso_r;

  assign mosi_s    = mosi_sync_r[1];
  assign csn_s     = csn_sync_r[1];
  assign rise_s    = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign fall_s    = ~sclk_sync_r[1] & sclk_sync_r[2];
  assign cs_rise_s = csn_sync_r[1] & ~csn_sync_r[2];
  assign cs_fall_s = ~csn_sync_r[1] & csn_sync_r[2];

  // Bring the asynchronous SPI pins into the clk domain.
  // CSn resets low so a reset taken mid-transfer waits for a fresh CSn high before re-arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      csn_sync_r  <= 3'b000;
      sclk_sync_r <= 3'b000;
      mosi_sync_r <= 2'b00;
    end else begin
      csn_sync_r  <= {csn_sync_r[1:0], spi_csn};
      sclk_sync_r <= {sclk_sync_r[1:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
    end
  end

  // Transaction FSM with receive/transmit shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= WAIT_IDLE;
      rx_sr_r   <= 8'h00;
      tx_sr_r   <= 8'h00;
      data_in_r <= 8'h00;
      bit_cnt_r <= 3'd0;
      first_r   <= 1'b0;
      strobe_r  <= 1'b0;
      start_r   <= 1'b0;
      miso_r    <= MISO_IDLE;
    end else begin
      strobe_r <= 1'b0;
      start_r  <= 1'b0;
      case (state_r)
        WAIT_IDLE: begin
          if (csn_s) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall_s) begin
            tx_sr_r   <= data_out;
            bit_cnt_r <= 3'd0;
            first_r   <= 1'b1;
            state_r   <= ACTIVE;
          end
        end
        ACTIVE: begin
          // CSn deassertion beats a coincident SCLK edge, dropping any partial byte
          if (cs_rise_s) begin
            bit_cnt_r <= 3'd0;
            state_r   <= IDLE;
          end else begin
            if (rise_s) begin
              rx_sr_r   <= {rx_sr_r[6:0], mosi_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                data_in_r <= {rx_sr_r[6:0], mosi_s};
                strobe_r  <= 1'b1;
                start_r   <= first_r;
                first_r   <= 1'b0;
              end
            end
            if (fall_s) begin
              if (bit_cnt_r == 3'd0) begin
                tx_sr_r <= data_out;
              end else begin
                tx_sr_r <= {tx_sr_r[6:0], 1'b0};
              end
            end
          end
        end
        default: begin
          state_r <= WAIT_IDLE;
        end
      endcase
      miso_r <= (state_r == ACTIVE) ? tx_sr_r[7] : MISO_IDLE;
    end
  end

  assign spi_miso       = miso_r;
  assign data_in_strobe = strobe_r;
  assign data_in_start  = start_r;
  assign data_in        = data_in_r;

endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed and max-rate random bench for mcu_spi_target: acts as the SPI master and as
// the downstream block returning response bytes; checks strobes, data, start, MISO, latency.
`timescale 1ns/1ps
module tb_mcu_spi_target;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_csn = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out = 8'hA7;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int start_cnt = 0;
  int wide_cnt = 0;
  int stray_start = 0;
  int last_strobe_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_start = 1'b0;
  logic       prev_strobe = 1'b0;

  mcu_spi_target #(.MISO_IDLE(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .spi_csn        (spi_csn),
    .spi_sclk       (spi_sclk),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor on the falling clk edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (data_in_strobe) begin
      strobe_cnt      <= strobe_cnt + 1;
      last_data       <= data_in;
      last_start      <= data_in_start;
      last_strobe_cyc <= cyc;
      if (data_in_start) start_cnt <= start_cnt + 1;
    end
    if (data_in_start && !data_in_strobe) stray_start <= stray_start + 1;
    if (data_in_strobe && prev_strobe) wide_cnt <= wide_cnt + 1;
    prev_strobe <= data_in_strobe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #HALF;
      spi_sclk = 1'b1;
      #HALF;
      spi_sclk = 1'b0;
    end
  endtask

  // One full byte; latency is counted from the clk edge that first samples the 8th SCLK high.
  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] resp,
                          output logic [7:0] rxm, output int lat);
    int s0;
    int c0;
    s0  = strobe_cnt;
    lat = -1;
    rxm = 8'h00;
    c0  = 0;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #HALF;
      spi_sclk = 1'b1;
      rxm[i]   = spi_miso;
      c0       = cyc;
      #HALF;
      if (i == 0) begin
        if (strobe_cnt != s0) lat = last_strobe_cyc - (c0 + 1);
        data_out = resp;
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic byte_chk(input string tag, input logic [7:0] tx, input logic [7:0] resp,
                          input logic [7:0] exp_miso, input logic exp_start);
    int s0;
    int lat;
    logic [7:0] m;
    s0 = strobe_cnt;
    spi_byte(tx, resp, m, lat);
    check({tag, ".strobes"}, 32'(strobe_cnt - s0), 32'd1);
    check({tag, ".data"}, 32'(last_data), 32'(tx));
    check({tag, ".start"}, 32'(last_start), 32'(exp_start));
    check({tag, ".miso"}, 32'(m), 32'(exp_miso));
    check({tag, ".latency"}, 32'(lat), 32'd2);
  endtask

  task automatic cs_start();
    spi_csn = 1'b0;
    #60;
  endtask

  task automatic cs_end(input int gap);
    #HALF;
    spi_csn = 1'b1;
    #(gap);
  endtask

  initial begin
    int s0;
    int st0;
    int nb;
    int len;
    int ph;
    int tp;
    int r;
    logic [7:0] exp_m;
    logic [7:0] tx;
    logic [7:0] resp;

    #7;
    #40;
    check("reset.strobe", 32'(data_in_strobe), 32'd0);
    check("reset.start", 32'(data_in_start), 32'd0);
    check("reset.data_in", 32'(data_in), 32'h00);
    check("reset.miso", 32'(spi_miso), 32'd0);
    reset = 1'b0;
    #60;

    // Basic command: response bytes come back one byte later
    cs_start();
    byte_chk("basic.b0", 8'h00, 8'h5C, 8'hA7, 1'b1);
    byte_chk("basic.b1", 8'hFF, 8'h42, 8'h5C, 1'b0);
    byte_chk("basic.b2", 8'h11, 8'h02, 8'h42, 1'b0);
    byte_chk("basic.b3", 8'h22, 8'hC1, 8'h02, 1'b0);
    cs_end(60);
    check("basic.miso_idle", 32'(spi_miso), 32'd0);

    // Multi-byte write
    st0 = start_cnt;
    s0  = strobe_cnt;
    cs_start();
    byte_chk("write.b0", 8'h04, 8'h10, 8'hC1, 1'b1);
    byte_chk("write.b1", 8'h53, 8'h20, 8'h10, 1'b0);
    byte_chk("write.b2", 8'h02, 8'h30, 8'h20, 1'b0);
    cs_end(60);
    check("write.strobes", 32'(strobe_cnt - s0), 32'd3);
    check("write.starts", 32'(start_cnt - st0), 32'd1);

    // Abort after 5 bits, then a clean transaction
    s0 = strobe_cnt;
    cs_start();
    spi_bits(8'hA5, 5);
    cs_end(60);
    check("abort.no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("abort.data_hold", 32'(data_in), 32'h02);
    cs_start();
    byte_chk("abort.b0", 8'h3C, 8'h80, 8'h30, 1'b1);
    cs_end(60);

    // Reset mid-transfer with CSn held low
    s0 = strobe_cnt;
    cs_start();
    spi_bits(8'hC3, 3);
    #10;
    reset = 1'b1;
    #30;
    check("rst.data_in", 32'(data_in), 32'h00);
    check("rst.strobe", 32'(data_in_strobe), 32'd0);
    check("rst.miso", 32'(spi_miso), 32'd0);
    reset = 1'b0;
    spi_bits(8'hFF, 8);
    #HALF;
    check("rst.no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("rst.data_hold", 32'(data_in), 32'h00);
    spi_csn = 1'b1;
    #60;
    cs_start();
    byte_chk("rst.b0", 8'h81, 8'h55, 8'h80, 1'b1);
    cs_end(60);

    // Back-to-back transactions with 2 clk of CSn high
    st0 = start_cnt;
    cs_start();
    byte_chk("b2b.a0", 8'h11, 8'h66, 8'h55, 1'b1);
    byte_chk("b2b.a1", 8'h22, 8'h77, 8'h66, 1'b0);
    cs_end(20);
    cs_start();
    byte_chk("b2b.b0", 8'h33, 8'h88, 8'h77, 1'b1);
    byte_chk("b2b.b1", 8'h44, 8'h99, 8'h88, 1'b0);
    cs_end(60);
    check("b2b.starts", 32'(start_cnt - st0), 32'd2);

    // Max rate: SCLK = clk/8, random phase per transaction, 256 random bytes
    nb = 0;
    while (nb < 256) begin
      len = $urandom_range(1, 8);
      if (len > 256 - nb) len = 256 - nb;
      ph = int'($time % 10);
      r  = $urandom_range(0, 7);
      tp = (r < 4) ? r + 1 : r + 2;
      #((tp - ph + 10) % 10);
      exp_m = data_out;
      cs_start();
      for (int k = 0; k < len; k++) begin
        tx   = 8'($urandom);
        resp = 8'($urandom);
        byte_chk("rate", tx, resp, exp_m, (k == 0));
        exp_m = resp;
        nb++;
      end
      cs_end(10 * $urandom_range(2, 5));
    end
    check("rate.miso_idle", 32'(spi_miso), 32'd0);

    check("strobe.width", 32'(wide_cnt), 32'd0);
    check("start.stray", 32'(stray_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
